decoder_stage_controller: RTL and testbench

Top-level sequencer for the single-FPGA union-find decoder PE array. It drives the shared `global_stage` bus that every processing unit registers. It decides when each stage is finished by watching the array-wide OR of PE `busy` and PE `odd`. It also handles the start/result handshake with the measurement front end and reports per-syndrome iteration and cycle statistics.

---
 rtl/decoder_stage_controller_pkg.sv | 16 +
 rtl/stage_settle_counter.sv | 30 +++
 rtl/decoder_stage_controller.sv | 145 ++++++++++++++
 tb/tb_decoder_stage_controller.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_stage_controller_pkg.sv
// Stage codes broadcast on the shared global_stage bus; the PE array decodes the same values.
package decoder_stage_controller_pkg;

    localparam int unsigned STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE                 = 3'd0,
        STAGE_MEASUREMENT_LOADING  = 3'd1,
        STAGE_GROW                 = 3'd2,
        STAGE_MERGE                = 3'd3,
        STAGE_PEELING              = 3'd4,
        STAGE_RESULT_VALID         = 3'd5,
        STAGE_STREAMING_CORRECTION = 3'd6
    } stage_e;

endpackage

// File: rtl/stage_settle_counter.sv
// Counts consecutive quiet (busy=0) cycles; settled marks the cycle in which a stage may exit.
module stage_settle_counter #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic busy,
    output logic settled
);

    localparam int unsigned      CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_quiet_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quiet_cnt <= '0;
        end else if (clr || busy) begin
            r_quiet_cnt <= '0;
        end else if (r_quiet_cnt != LAST) begin
            r_quiet_cnt <= r_quiet_cnt + CNT_W'(1);
        end
    end

    // A busy pulse in the would-be exit cycle blocks the exit and restarts the count.
    assign settled = !busy && (r_quiet_cnt == LAST);

endmodule

// File: rtl/decoder_stage_controller.sv
// Stage sequencer for the union-find PE array: drives global_stage, runs the
// start/result handshake and reports per-syndrome iteration and latency statistics.
module decoder_stage_controller
    import decoder_stage_controller_pkg::*;
#(
    parameter int unsigned GROW_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned ITER_WIDTH    = 8,
    parameter int unsigned MAX_ITER      = 255,
    parameter int unsigned CYCLE_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    output logic [STAGE_WIDTH-1:0] global_stage,
    input  logic                   busy_any,
    input  logic                   odd_any,
    output logic                   result_valid,
    output logic [ITER_WIDTH-1:0]  iteration_count,
    output logic [CYCLE_WIDTH-1:0] cycle_count,
    output logic                   timeout
);

    localparam int unsigned GROW_W = $clog2(GROW_CYCLES) + 1;

    stage_e                 r_state;
    stage_e                 w_next;
    logic                   w_start_acc;
    logic                   w_grow_entry;
    logic                   w_timeout_set;
    logic                   w_settled;
    logic                   w_settle_clr;
    logic                   w_grow_done;
    logic                   w_counting;
    logic [GROW_W-1:0]      r_grow_cnt;
    logic                   r_ready;
    logic                   r_result_valid;
    logic [ITER_WIDTH-1:0]  r_iter;
    logic [CYCLE_WIDTH-1:0] r_cycle;
    logic                   r_timeout;

    assign w_grow_done  = (r_grow_cnt == GROW_W'(GROW_CYCLES - 1));
    assign w_counting   = (r_state == STAGE_MEASUREMENT_LOADING) || (r_state == STAGE_GROW) ||
                          (r_state == STAGE_MERGE) || (r_state == STAGE_PEELING);
    // Quiet count only runs inside MERGE/PEELING and restarts on every stage change.
    assign w_settle_clr = (w_next != r_state) ||
                          !((r_state == STAGE_MERGE) || (r_state == STAGE_PEELING));

    stage_settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_settle_clr),
        .busy   (busy_any),
        .settled(w_settled)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= STAGE_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start_acc   = 1'b0;
        w_grow_entry  = 1'b0;
        w_timeout_set = 1'b0;
        case (r_state)
            STAGE_IDLE: begin
                if (start) begin
                    w_next      = STAGE_MEASUREMENT_LOADING;
                    w_start_acc = 1'b1;
                end
            end
            STAGE_MEASUREMENT_LOADING: w_next = STAGE_MERGE;
            STAGE_GROW: begin
                if (w_grow_done) w_next = STAGE_MERGE;
            end
            STAGE_MERGE: begin
                if (w_settled) begin
                    if (!odd_any) begin
                        w_next = STAGE_PEELING;
                    end else if (r_iter < ITER_WIDTH'(MAX_ITER)) begin
                        w_next       = STAGE_GROW;
                        w_grow_entry = 1'b1;
                    end else begin
                        w_next        = STAGE_PEELING;
                        w_timeout_set = 1'b1;
                    end
                end
            end
            STAGE_PEELING: begin
                if (w_settled) w_next = STAGE_RESULT_VALID;
            end
            STAGE_RESULT_VALID: w_next = STAGE_IDLE;
            default:            w_next = STAGE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grow_cnt <= '0;
        end else if ((r_state == STAGE_GROW) && (w_next == STAGE_GROW)) begin
            r_grow_cnt <= r_grow_cnt + GROW_W'(1);
        end else begin
            r_grow_cnt <= '0;
        end
    end

    // Statistics clear on accept and hold from RESULT until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready        <= 1'b1;
            r_result_valid <= 1'b0;
            r_iter         <= '0;
            r_cycle        <= '0;
            r_timeout      <= 1'b0;
        end else begin
            r_ready        <= (w_next == STAGE_IDLE);
            r_result_valid <= (w_next == STAGE_RESULT_VALID);
            if (w_start_acc) begin
                r_iter    <= '0;
                r_cycle   <= '0;
                r_timeout <= 1'b0;
            end else begin
                if (w_grow_entry) r_iter <= r_iter + ITER_WIDTH'(1);
                if (w_timeout_set) r_timeout <= 1'b1;
                if (w_counting && (r_cycle != '1)) r_cycle <= r_cycle + CYCLE_WIDTH'(1);
            end
        end
    end

    assign global_stage    = r_state;
    assign ready           = r_ready;
    assign result_valid    = r_result_valid;
    assign iteration_count = r_iter;
    assign cycle_count     = r_cycle;
    assign timeout         = r_timeout;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Bench for decoder_stage_controller: randomized PE busy/odd activity against a
// stage-trace reference model; a second instance with a 4-bit latency counter covers saturation.
module tb_decoder_stage_controller;
    import decoder_stage_controller_pkg::*;

    localparam int unsigned GROW  = 2;
    localparam int unsigned SETTLE = 3;
    localparam int unsigned MAXI  = 3;

    localparam logic [2:0] S_IDLE   = 3'(STAGE_IDLE);
    localparam logic [2:0] S_LOAD   = 3'(STAGE_MEASUREMENT_LOADING);
    localparam logic [2:0] S_GROW   = 3'(STAGE_GROW);
    localparam logic [2:0] S_MERGE  = 3'(STAGE_MERGE);
    localparam logic [2:0] S_PEEL   = 3'(STAGE_PEELING);
    localparam logic [2:0] S_RESULT = 3'(STAGE_RESULT_VALID);

    typedef struct packed {
        logic [2:0]  stage;
        logic        ready;
        logic        rv;
        logic [7:0]  iter;
        logic [15:0] cyc;
        logic        to;
    } obs_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy_any;
    logic        odd_any;
    logic        ready;
    logic [2:0]  global_stage;
    logic        result_valid;
    logic [7:0]  iteration_count;
    logic [15:0] cycle_count;
    logic        timeout;
    logic        sat_ready;
    logic [2:0]  sat_stage;
    logic        sat_rv;
    logic [7:0]  sat_iter;
    logic [3:0]  sat_cyc;
    logic        sat_to;

    int n_checks;
    int n_fail;

    obs_t obs_q[$];
    obs_t sat_q[$];
    obs_t exp_q[$];
    obs_t exp_sat_q[$];

    int          n_odd;
    logic [15:0] merge_mask [8];
    logic [15:0] peel_mask;
    int          merge_dur [8];
    int          peel_dur;

    decoder_stage_controller #(
        .GROW_CYCLES(GROW), .SETTLE_CYCLES(SETTLE), .ITER_WIDTH(8), .MAX_ITER(MAXI), .CYCLE_WIDTH(16)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .global_stage(global_stage),
        .busy_any(busy_any), .odd_any(odd_any), .result_valid(result_valid),
        .iteration_count(iteration_count), .cycle_count(cycle_count), .timeout(timeout)
    );

    decoder_stage_controller #(
        .GROW_CYCLES(GROW), .SETTLE_CYCLES(SETTLE), .ITER_WIDTH(8), .MAX_ITER(MAXI), .CYCLE_WIDTH(4)
    ) u_dut_sat (
        .clk(clk), .reset(reset), .start(start), .ready(sat_ready), .global_stage(sat_stage),
        .busy_any(busy_any), .odd_any(odd_any), .result_valid(sat_rv),
        .iteration_count(sat_iter), .cycle_count(sat_cyc), .timeout(sat_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fmt(input obs_t o);
        return $sformatf("stage=%0d rdy=%0b rv=%0b iter=%0d cyc=%0d to=%0b",
                         o.stage, o.ready, o.rv, o.iter, o.cyc, o.to);
    endfunction

    // A phase ends once SETTLE consecutive quiet cycles have been seen inside it.
    function automatic int quiet_dur(input logic [15:0] mask);
        int run = 0;
        for (int o = 0; o < 40; o++) begin
            if (o < 16 && mask[o[3:0]] == 1'b1) run = 0;
            else run++;
            if (run == int'(SETTLE)) return o + 1;
        end
        return 40;
    endfunction

    // Expected per-cycle trace from LOAD through the IDLE cycle after RESULT.
    function automatic void build_expected();
        logic [2:0] sq[$];
        int   grows;
        bit   tcase;
        int   iter;
        int   res_idx;
        int   c;
        obs_t e;
        grows = (n_odd < int'(MAXI)) ? n_odd : int'(MAXI);
        tcase = (n_odd > int'(MAXI));
        sq.push_back(S_LOAD);
        for (int m = 0; m <= grows; m++) begin
            merge_dur[m] = quiet_dur(merge_mask[m]);
            for (int k = 0; k < merge_dur[m]; k++) sq.push_back(S_MERGE);
            if (m < grows) for (int k = 0; k < int'(GROW); k++) sq.push_back(S_GROW);
        end
        peel_dur = quiet_dur(peel_mask);
        for (int k = 0; k < peel_dur; k++) sq.push_back(S_PEEL);
        sq.push_back(S_RESULT);
        sq.push_back(S_IDLE);
        res_idx = sq.size() - 2;
        exp_q.delete();
        exp_sat_q.delete();
        iter = 0;
        for (int i = 0; i < sq.size(); i++) begin
            if (sq[i] == S_GROW && (i == 0 || sq[i-1] != S_GROW)) iter++;
            c        = (i < res_idx) ? i : res_idx;
            e.stage  = sq[i];
            e.ready  = (sq[i] == S_IDLE);
            e.rv     = (sq[i] == S_RESULT);
            e.iter   = 8'(iter);
            e.to     = tcase && (sq[i] == S_PEEL || sq[i] == S_RESULT || sq[i] == S_IDLE);
            e.cyc    = 16'((c > 65535) ? 65535 : c);
            exp_q.push_back(e);
            e.cyc    = 16'((c > 15) ? 15 : c);
            exp_sat_q.push_back(e);
        end
    endfunction

    // Acts as the PE array: drives busy/odd per phase plan and records both instances each cycle.
    task automatic run_decode(input bit hold_start);
        logic [2:0] st;
        logic [2:0] prev;
        int   off;
        int   midx;
        bit   seen_result;
        bit   done;
        obs_t o;
        obs_t s;
        obs_q.delete();
        sat_q.delete();
        start = 1'b1;
        @(posedge clk);
        prev = 3'd7;
        off = 0;
        midx = -1;
        seen_result = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            st = global_stage;
            o.stage = st;        o.ready = ready;     o.rv = result_valid;
            o.iter  = iteration_count; o.cyc = cycle_count; o.to = timeout;
            s.stage = sat_stage; s.ready = sat_ready; s.rv = sat_rv;
            s.iter  = sat_iter;  s.cyc = 16'(sat_cyc); s.to = sat_to;
            obs_q.push_back(o);
            sat_q.push_back(s);
            if (seen_result) done = 1'b1;
            if (st == S_RESULT) seen_result = 1'b1;
            if (st != prev) begin
                off = 0;
                if (st == S_MERGE) midx++;
            end else begin
                off++;
            end
            prev = st;
            busy_any = 1'($urandom);
            odd_any  = 1'($urandom);
            if (st == S_MERGE && midx >= 0 && midx < 8) begin
                busy_any = (off < 16) ? merge_mask[midx][off[3:0]] : 1'b0;
                if (off == merge_dur[midx] - 1) odd_any = (midx < n_odd);
            end else if (st == S_PEEL) begin
                busy_any = (off < 16) ? peel_mask[off[3:0]] : 1'b0;
            end
        end
    endtask

    task automatic clear_plan();
        n_odd = 0;
        peel_mask = '0;
        for (int m = 0; m < 8; m++) merge_mask[m] = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; busy_any = 1'b0; odd_any = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({global_stage, ready, result_valid, iteration_count, cycle_count, timeout} !==
            {S_IDLE, 1'b1, 1'b0, 8'd0, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got stage=%0d rdy=%0b rv=%0b iter=%0d cyc=%0d to=%0b, expected 0 1 0 0 0 0",
                     global_stage, ready, result_valid, iteration_count, cycle_count, timeout);
        end
        reset = 1'b0;
        busy_any = 1'b1; odd_any = 1'b1;
        @(negedge clk);
        n_checks++;
        if (global_stage !== S_IDLE || ready !== 1'b1 || sat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: got stage=%0d rdy=%0b sat_rdy=%0b, expected 0 1 1",
                     global_stage, ready, sat_ready);
        end
    endtask

    task automatic test_empty();
        obs_t r;
        int   res_i;
        clear_plan();
        build_expected();
        run_decode(1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL empty trace_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL empty cycle %0d: got %s expected %s", i + 1, fmt(obs_q[i]), fmt(exp_q[i]));
            end
            n_checks++;
            if (sat_q[i] !== exp_sat_q[i]) begin
                n_fail++;
                $display("FAIL empty_sat cycle %0d: got %s expected %s", i + 1, fmt(sat_q[i]), fmt(exp_sat_q[i]));
            end
        end
        res_i = -1;
        for (int i = 0; i < obs_q.size(); i++) if (res_i < 0 && obs_q[i].stage == S_RESULT) res_i = i;
        r = (res_i >= 0) ? obs_q[res_i] : '0;
        n_checks++;
        if (res_i != 7 || r.cyc !== 16'd7 || r.iter !== 8'd0) begin
            n_fail++;
            $display("FAIL empty_latency: got result at cycle %0d cyc=%0d iter=%0d, expected cycle 8 cyc=7 iter=0",
                     res_i + 1, r.cyc, r.iter);
        end
    endtask

    task automatic test_two_grow();
        obs_t r;
        int   res_i;
        int   runs;
        int   run_len;
        bit   bad_len;
        clear_plan();
        n_odd = 2;
        for (int m = 0; m < 8; m++) merge_mask[m] = 16'h0003;
        build_expected();
        run_decode(1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL two_grow trace_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL two_grow cycle %0d: got %s expected %s", i + 1, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
        runs = 0; run_len = 0; bad_len = 1'b0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i].stage == S_GROW) run_len++;
            if (run_len > 0 && (i == obs_q.size() - 1 || obs_q[i+1].stage != S_GROW)) begin
                runs++;
                if (run_len != int'(GROW)) bad_len = 1'b1;
                run_len = 0;
            end
        end
        n_checks++;
        if (runs != 2 || bad_len) begin
            n_fail++;
            $display("FAIL two_grow_dwell: got %0d grow stages (bad length=%0b), expected 2 of %0d cycles",
                     runs, bad_len, GROW);
        end
        res_i = -1;
        for (int i = 0; i < obs_q.size(); i++) if (res_i < 0 && obs_q[i].stage == S_RESULT) res_i = i;
        r = (res_i >= 0) ? obs_q[res_i] : '0;
        n_checks++;
        if (r.rv !== 1'b1 || r.iter !== 8'd2 || r.to !== 1'b0) begin
            n_fail++;
            $display("FAIL two_grow_result: got rv=%0b iter=%0d to=%0b, expected rv=1 iter=2 to=0", r.rv, r.iter, r.to);
        end
    endtask

    task automatic test_busy_glitch();
        int mlen;
        clear_plan();
        merge_mask[0] = 16'h0004;
        build_expected();
        run_decode(1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL glitch trace_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL glitch cycle %0d: got %s expected %s", i + 1, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
        mlen = 0;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].stage == S_MERGE) mlen++;
        n_checks++;
        if (mlen != int'(SETTLE) + 3) begin
            n_fail++;
            $display("FAIL glitch_merge_dwell: got %0d cycles expected %0d", mlen, SETTLE + 3);
        end
    endtask

    task automatic test_timeout();
        obs_t r;
        int   res_i;
        int   runs;
        clear_plan();
        n_odd = 8;
        for (int m = 0; m < 8; m++) merge_mask[m] = 16'($urandom) & 16'($urandom) & 16'h001f;
        peel_mask = 16'($urandom) & 16'h001f;
        build_expected();
        run_decode(1'b0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL timeout trace_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: got %s expected %s", i + 1, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
        runs = 0;
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i].stage == S_GROW && (i == 0 || obs_q[i-1].stage != S_GROW)) runs++;
        res_i = -1;
        for (int i = 0; i < obs_q.size(); i++) if (res_i < 0 && obs_q[i].stage == S_RESULT) res_i = i;
        r = (res_i >= 0) ? obs_q[res_i] : '0;
        n_checks++;
        if (runs != int'(MAXI) || r.iter !== 8'(MAXI) || r.to !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_result: got grows=%0d iter=%0d to=%0b, expected grows=3 iter=3 to=1",
                     runs, r.iter, r.to);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            clear_plan();
            n_odd = int'($urandom_range(0, 5));
            for (int m = 0; m < 8; m++) merge_mask[m] = 16'($urandom) & 16'($urandom) & 16'h03ff;
            peel_mask = 16'($urandom) & 16'($urandom) & 16'h03ff;
            build_expected();
            run_decode(1'b0);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL random%0d trace_len: got %0d expected %0d", t, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random%0d cycle %0d: got %s expected %s", t, i + 1, fmt(obs_q[i]), fmt(exp_q[i]));
                end
                n_checks++;
                if (sat_q[i] !== exp_sat_q[i]) begin
                    n_fail++;
                    $display("FAIL random%0d_sat cycle %0d: got %s expected %s", t, i + 1, fmt(sat_q[i]), fmt(exp_sat_q[i]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_plan();
        n_odd = 1;
        merge_mask[0] = 16'h0001;
        peel_mask = 16'h0002;
        build_expected();
        for (int k = 0; k < 2; k++) begin
            run_decode(1'b1);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL back_to_back%0d trace_len: got %0d expected %0d", k, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL back_to_back%0d cycle %0d: got %s expected %s", k, i + 1, fmt(obs_q[i]), fmt(exp_q[i]));
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit rv_seen;
        bit not_idle;
        start = 1'b1;
        busy_any = 1'b0;
        odd_any = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && global_stage != S_PEEL; k++) @(negedge clk);
        n_checks++;
        if (global_stage !== S_PEEL) begin
            n_fail++;
            $display("FAIL reset_mid_reach_peeling: got stage=%0d expected %0d", global_stage, S_PEEL);
        end
        busy_any = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({global_stage, ready, result_valid, iteration_count, cycle_count, timeout} !==
            {S_IDLE, 1'b1, 1'b0, 8'd0, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_values: got stage=%0d rdy=%0b rv=%0b iter=%0d cyc=%0d to=%0b, expected 0 1 0 0 0 0",
                     global_stage, ready, result_valid, iteration_count, cycle_count, timeout);
        end
        @(negedge clk);
        reset = 1'b0;
        busy_any = 1'b0;
        rv_seen = 1'b0;
        not_idle = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (result_valid || sat_rv) rv_seen = 1'b1;
            if (global_stage != S_IDLE) not_idle = 1'b1;
        end
        n_checks++;
        if (rv_seen || not_idle) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got result_valid_seen=%0b left_idle=%0b, expected 0 0", rv_seen, not_idle);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_empty();
        test_two_grow();
        test_busy_glitch();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
